// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin arbiter FSM.
package arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_GRANT = 2'b01,
        S_GAP   = 2'b10
    } arb_state_e;

    // Wide decode; callers keep the low NREQ bits.
    function automatic logic [31:0] onehot(input logic [31:0] idx);
        return 32'd1 << idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin pick: first set request scanning last+1, last+2, ... wrapping.
module rr_pick #(
    parameter int NREQ = 3,
    localparam int IW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last,
    output logic            valid,
    output logic [IW-1:0]   idx
);

    // Scan farthest-first so the nearest candidate after last overwrites.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int i = NREQ; i >= 1; i--) begin
            if (req[IW'((int'(last) + i) % NREQ)]) begin
                valid = 1'b1;
                idx   = IW'((int'(last) + i) % NREQ);
            end
        end
    end

endmodule

// File: rtl/rr_arbiter_fsm.sv
// Round-robin arbiter sharing one resource among NREQ requesters, with a
// hold limit and a one-cycle turnaround gap between owners.
module rr_arbiter_fsm
    import arb_pkg::*;
#(
    parameter int NREQ     = 3,
    parameter int MAX_HOLD = 8,
    localparam int IW = $clog2(NREQ),
    localparam int HW = $clog2(MAX_HOLD)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   owner,
    output logic            busy,
    output logic            grant_start,
    output logic            timeout,
    output logic [1:0]      state_dbg
);

    // Handshake: a requester holds req high until done; grant_start marks the
    // winning cycle, gnt follows one cycle later and stays while req is held
    // (up to MAX_HOLD cycles); dropping req releases the resource.

    arb_state_e      ps, ns;
    logic [IW-1:0]   last;
    logic [HW-1:0]   hold_cnt;
    logic            pick_valid;
    logic [IW-1:0]   pick_idx;
    logic [31:0]     oh;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req   (req),
        .last  (last),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    assign oh        = onehot(32'(owner));
    assign state_dbg = ps;

    // Mealy pulses are masked during reset so no arbitration or timeout is
    // reported on a cycle that is about to be discarded.
    always_comb begin
        ns          = S_IDLE;
        gnt         = '0;
        busy        = 1'b0;
        grant_start = 1'b0;
        timeout     = 1'b0;
        case (ps)
            S_IDLE: begin
                if (pick_valid) begin
                    ns          = S_GRANT;
                    grant_start = !reset;
                end
            end
            S_GRANT: begin
                gnt  = oh[NREQ-1:0];
                busy = 1'b1;
                if (!req[owner]) begin
                    ns = S_GAP;
                end else if (hold_cnt == HW'(MAX_HOLD - 1)) begin
                    ns      = S_GAP;
                    timeout = !reset;
                end else begin
                    ns = S_GRANT;
                end
            end
            S_GAP: begin
                busy = 1'b1;
                if (pick_valid) begin
                    ns          = S_GRANT;
                    grant_start = !reset;
                end
            end
            default: ns = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ps       <= S_IDLE;
            owner    <= '0;
            last     <= IW'(NREQ - 1);
            hold_cnt <= '0;
        end else begin
            ps <= ns;
            if (ns == S_GRANT && ps != S_GRANT) begin
                owner    <= pick_idx;
                hold_cnt <= '0;
            end else if (ns == S_GRANT) begin
                hold_cnt <= hold_cnt + 1'b1;
            end
            if (ps == S_GRANT && ns != S_GRANT) begin
                last <= owner;
            end
        end
    end

endmodule

// File: tb/tb_rr_arbiter_fsm.sv
// Scoreboard bench for rr_arbiter_fsm against a cycle-level ownership model.
module tb_rr_arbiter_fsm;

    localparam int NREQ     = 3;
    localparam int MAX_HOLD = 4;
    localparam int IW       = $clog2(NREQ);
    localparam int W        = NREQ + IW + 3;

    logic            clk;
    logic            reset;
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] gnt;
    logic [IW-1:0]   owner;
    logic            busy;
    logic            grant_start;
    logic            timeout;
    logic [1:0]      state_dbg;

    int errors = 0;
    int checks = 0;
    logic [W-1:0] exp_q[$];

    // Model: who holds the resource, for how many cycles, whether a gap is due.
    int m_holder = -1;
    int m_held   = 0;
    int m_last   = NREQ - 1;
    int m_owner  = 0;
    bit m_gap    = 1'b0;

    rr_arbiter_fsm #(.NREQ(NREQ), .MAX_HOLD(MAX_HOLD)) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .gnt         (gnt),
        .owner       (owner),
        .busy        (busy),
        .grant_start (grant_start),
        .timeout     (timeout),
        .state_dbg   (state_dbg)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic model_step(input bit rst, input logic [NREQ-1:0] r,
                              output logic [W-1:0] e);
        logic [NREQ-1:0] g;
        logic [NREQ-1:0] sh;
        bit b, gs, to;
        int pick;
        g  = (m_holder >= 0) ? (NREQ'(1) << m_holder) : '0;
        b  = (m_holder >= 0) || m_gap;
        gs = 1'b0;
        to = 1'b0;
        e  = {g, IW'(m_owner), b, 1'b0, 1'b0};
        if (rst) begin
            m_holder = -1;
            m_held   = 0;
            m_gap    = 1'b0;
            m_last   = NREQ - 1;
            m_owner  = 0;
        end else if (m_holder >= 0) begin
            m_held = m_held + 1;
            sh = r >> m_holder;
            if (!sh[0] || m_held == MAX_HOLD) begin
                to       = sh[0];
                m_last   = m_holder;
                m_holder = -1;
                m_gap    = 1'b1;
            end
        end else begin
            m_gap = 1'b0;
            if (r != '0) begin
                pick = -1;
                for (int k = 1; k <= NREQ && pick < 0; k++) begin
                    sh = r >> ((m_last + k) % NREQ);
                    if (sh[0]) pick = (m_last + k) % NREQ;
                end
                gs       = 1'b1;
                m_holder = pick;
                m_owner  = pick;
                m_held   = 0;
            end
        end
        e[1] = gs;
        e[0] = to;
    endtask

    task automatic drive(input bit rst, input logic [NREQ-1:0] r);
        logic [W-1:0] e;
        @(posedge clk);
        #1;
        reset = rst;
        req   = r;
        model_step(rst, r, e);
        exp_q.push_back(e);
    endtask

    // Monitor: every cycle is an output beat; compare mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [W-1:0] e;
            logic [W-1:0] a;
            e = exp_q.pop_front();
            a = {gnt, owner, busy, grant_start, timeout};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL beat%0d {gnt,owner,busy,gs,to}: got %b_%0d_%b%b%b want %b_%0d_%b%b%b",
                         checks, a[W-1 -: NREQ], a[IW+2:3], a[2], a[1], a[0],
                         e[W-1 -: NREQ], e[IW+2:3], e[2], e[1], e[0]);
            end
        end
    end

    initial begin
        logic [NREQ-1:0] r;
        logic [NREQ-1:0] sh;
        reset = 1'b1;
        req   = '0;
        @(posedge clk);

        // Reset held with all requests pending; first grant goes to req0.
        drive(1, 3'b111);
        drive(1, 3'b111);
        drive(0, 3'b111);
        drive(0, 3'b000);
        repeat (3) drive(0, 3'b000);

        // Single requester: grant, release, gap, idle.
        drive(0, 3'b001);
        drive(0, 3'b001);
        drive(0, 3'b001);
        repeat (3) drive(0, 3'b000);

        // All requesting, each owner drops one cycle after its grant.
        for (int c = 0; c < 12; c++) begin
            r = 3'b111;
            if (m_holder >= 0 && m_held >= 1) begin
                sh = NREQ'(1) << m_holder;
                r  = r & ~sh;
            end
            drive(0, r);
        end
        repeat (3) drive(0, 3'b000);

        // Sole requester hits the hold limit and is re-granted after the gap.
        repeat (8) drive(0, 3'b010);
        // Two requesters: owner 1 times out, scan wraps to 0.
        repeat (10) drive(0, 3'b011);
        repeat (3) drive(0, 3'b000);

        // Reset during the second grant cycle.
        drive(0, 3'b010);
        drive(0, 3'b010);
        drive(1, 3'b010);
        drive(0, 3'b111);
        drive(0, 3'b111);
        repeat (3) drive(0, 3'b000);

        // Random traffic with sticky requests and rare resets.
        r = '0;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 3) == 0) r = NREQ'($urandom_range(0, 7));
            drive($urandom_range(0, 39) == 0, r);
        end
        drive(0, 3'b000);

        repeat (2) @(posedge clk);
        #1;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d beats left, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
